// File: rtl/adder_pkg.sv
// Shared types and constant helpers for the pipelined carry-bypass adder.
// The stage payload is sized to PBA_MAX_W; instances may use any W up to that.
package adder_pkg;

    localparam int PBA_MAX_W = 32;

    // One pipeline stage: partial sum so far, carry into the next block group,
    // and the operand bits the remaining groups still have to consume.
    typedef struct packed {
        logic                 valid;
        logic [PBA_MAX_W-1:0] psum;
        logic                 carry;
        logic [PBA_MAX_W-1:0] a_hi;
        logic [PBA_MAX_W-1:0] b_eff_hi;
        logic                 a_msb;
        logic                 b_msb;
    } stage_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic logic [PBA_MAX_W-1:0] sat_max(input int w);
        return {PBA_MAX_W{1'b1}} >> (PBA_MAX_W - w + 1);
    endfunction

    function automatic logic [PBA_MAX_W-1:0] sat_min(input int w);
        return {{(PBA_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

endpackage

// File: rtl/bypass_block.sv
// N-bit ripple block whose carry-out bypasses the ripple chain when every
// bit propagates.
module bypass_block #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N-1:0] p;
    logic [N:0]   c;

    assign p = a ^ b;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]   = p[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
        end
    end

    assign co = (&p) ? ci : c[N];

endmodule

// File: rtl/pipelined_bypass_adder.sv
// Pipelined carry-bypass adder/subtractor with valid/ready flow control and a
// saturating overflow counter. Define PBA_SATURATE_EN to clamp sum on overflow.
module pipelined_bypass_adder
    import adder_pkg::*;
#(
    parameter int W      = 32,
    parameter int N      = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     sum,
    output logic             cout,
    output logic             overflow,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             ovf_clr
);

    localparam int NB  = W / N;
    localparam int BPS = ceil_div(NB, STAGES);

    if (W % N != 0) begin : g_bad_n
        $error("W must be a multiple of N");
    end
    if (STAGES < 1 || STAGES > NB) begin : g_bad_stages
        $error("STAGES must lie in 1..W/N");
    end
    if (W > PBA_MAX_W) begin : g_bad_w
        $error("W exceeds PBA_MAX_W");
    end

    stage_t       in_pld;
    stage_t       stage_src [STAGES];
    stage_t       stage_d   [STAGES];
    stage_t       stage_q   [STAGES];
    logic [N-1:0] blk_s     [NB];
    logic         blk_co    [NB];
    logic [STAGES-1:0] ld;

    always_comb begin
        in_pld          = '0;
        in_pld.valid    = in_valid;
        in_pld.carry    = cin ^ sub;
        in_pld.a_hi     = PBA_MAX_W'(a);
        in_pld.b_eff_hi = PBA_MAX_W'(sub ? ~b : b);
        in_pld.a_msb    = a[W-1];
        in_pld.b_msb    = b[W-1] ^ sub;
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_src
        if (g == 0) begin : g_first
            assign stage_src[g] = in_pld;
        end else begin : g_next
            assign stage_src[g] = stage_q[g-1];
        end
    end

    // Each block reads the operands of the stage that owns it; the first block
    // of a group takes the carry registered by the previous stage.
    for (genvar j = 0; j < NB; j++) begin : g_blk
        localparam int GI = j / BPS;
        logic blk_ci;
        if (j % BPS == 0) begin : g_head
            assign blk_ci = stage_src[GI].carry;
        end else begin : g_chain
            assign blk_ci = blk_co[j-1];
        end
        bypass_block #(.N(N)) u_blk (
            .a  (stage_src[GI].a_hi[j*N +: N]),
            .b  (stage_src[GI].b_eff_hi[j*N +: N]),
            .ci (blk_ci),
            .s  (blk_s[j]),
            .co (blk_co[j])
        );
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int LO = g * BPS;
        localparam int HI = ((g + 1) * BPS < NB) ? (g + 1) * BPS : NB;
        stage_t nxt;
        always_comb begin
            nxt = stage_src[g];
            for (int j = LO; j < HI; j++) begin
                nxt.psum[j*N +: N] = blk_s[j];
            end
            if (HI > LO) begin
                nxt.carry = blk_co[HI-1];
            end
        end
        assign stage_d[g] = nxt;
    end

    // Ready ripples upstream: a stage may load if it is empty or draining.
    always_comb begin : ready_chain
        logic down_ready;
        logic go;
        ld         = '0;
        go         = 1'b0;
        down_ready = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go         = stage_q[k].valid && down_ready;
            ld[k]      = !stage_q[k].valid || go;
            down_ready = !stage_q[k].valid || go;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    // NOTE: the payload registers are reset too, because sum/cout/overflow are
    // decoded straight from the last stage and must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    if (stage_src[k].valid) begin
                        stage_q[k] <= stage_d[k];
                    end else begin
                        stage_q[k].valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = stage_q[STAGES-1].valid;
    assign cout      = stage_q[STAGES-1].carry;
    assign overflow  = (stage_q[STAGES-1].a_msb == stage_q[STAGES-1].b_msb) &&
                       (stage_q[STAGES-1].psum[W-1] != stage_q[STAGES-1].a_msb);

`ifdef PBA_SATURATE_EN
    localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
    localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));
    assign sum = overflow ? (stage_q[STAGES-1].a_msb ? SAT_MIN : SAT_MAX)
                          : stage_q[STAGES-1].psum[W-1:0];
`else
    assign sum = stage_q[STAGES-1].psum[W-1:0];
`endif

    // A clear in the same cycle as a counted delivery wins.
    always_ff @(posedge clk) begin
        if (rst || ovf_clr) begin
            ovf_cnt <= '0;
        end else if (out_valid && out_ready && overflow && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipelined_bypass_adder.sv
// Self-checking bench: directed cases plus random traffic scored against an
// integer-arithmetic model; a second instance uses a 2-bit overflow counter.
module tb_pipelined_bypass_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_ready;
    logic        ovf_clr;

    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [31:0] sum,       sum2;
    logic        cout,      cout2;
    logic        overflow,  overflow2;
    logic [15:0] ovf_cnt;
    logic [1:0]  ovf_cnt2;

    int errors = 0;
    int checks = 0;
    int delivered = 0;
    int m_cnt = 0;
    int m_cnt2 = 0;
    exp_t sb[$];

    pipelined_bypass_adder #(.W(32), .N(4), .STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow),
        .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
    );

    pipelined_bypass_adder #(.W(32), .N(4), .STAGES(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid2), .out_ready(out_ready),
        .sum(sum2), .cout(cout2), .overflow(overflow2),
        .ovf_cnt(ovf_cnt2), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Result of a +/- b +/- cin as plain integers, then wrapped or clamped.
    function automatic exp_t model(input logic [31:0] xa, input logic [31:0] xb,
                                   input logic xc, input logic xs);
        exp_t   e;
        longint sa, sbv, ua, ub, r;
        sa  = longint'($signed(xa));
        sbv = longint'($signed(xb));
        ua  = longint'(xa);
        ub  = longint'(xb);
        if (!xs) begin
            r      = sa + sbv + longint'(xc);
            e.cout = (ua + ub + longint'(xc)) >= 64'sd4294967296;
        end else begin
            r      = sa - sbv - longint'(xc);
            e.cout = ua >= (ub + longint'(xc));
        end
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.sum = r[31:0];
`ifdef PBA_SATURATE_EN
        if (e.ovf) e.sum = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return e;
    endfunction

    // One clock: observe handshakes before the edge, update the model, advance.
    task automatic step();
        exp_t e;
        logic hit;
        hit = 1'b0;
        #1;
        if (rst) begin
            sb.delete();
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            check("ovf_cnt", 64'(ovf_cnt), 64'(m_cnt));
            check("ovf_cnt_w2", 64'(ovf_cnt2), 64'(m_cnt2));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sum", 64'(sum), 64'(e.sum));
                    check("cout", 64'(cout), 64'(e.cout));
                    check("overflow", 64'(overflow), 64'(e.ovf));
                    check("w2_valid", 64'(out_valid2), 64'd1);
                    check("w2_sum", 64'(sum2), 64'(e.sum));
                    check("w2_cout", 64'(cout2), 64'(e.cout));
                    check("w2_overflow", 64'(overflow2), 64'(e.ovf));
                    delivered++;
                    hit = e.ovf;
                end
            end
            if (ovf_clr) begin
                m_cnt  = 0;
                m_cnt2 = 0;
            end else if (hit) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, cin, sub));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] xa, input logic [31:0] xb,
                        input logic xc, input logic xs);
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
        #1;
        check("send_in_ready", 64'(in_ready), 64'd1);
        check("send_in_ready_w2", 64'(in_ready2), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() > 0; i++) step();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; in_valid = 1'b1; a = 32'd3; b = 32'd4; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1; ovf_clr = 1'b0;

        // Reset with in_valid held high
        step();
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Plain add and latency
        send(32'd21, 32'd10, 1'b0, 1'b0);
        check("lat_not_early", 64'(out_valid), 64'd0);
        step();
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("add_sum", 64'(sum), 64'd31);
        check("add_cout", 64'(cout), 64'd0);
        step();

        // Signed overflow
        send(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0);
        step();
        check("ovf_flag", 64'(overflow), 64'd1);
`ifdef PBA_SATURATE_EN
        check("ovf_sum", 64'(sum), 64'h7FFF_FFFF);
`else
        check("ovf_sum", 64'(sum), 64'h8000_0000);
`endif
        step();
        check("ovf_cnt_one", 64'(ovf_cnt), 64'd1);

        // Subtract
        send(32'd5, 32'd7, 1'b0, 1'b1);
        step();
        check("sub_sum", 64'(sum), 64'hFFFF_FFFE);
        check("sub_cout", 64'(cout), 64'd0);
        check("sub_ovf", 64'(overflow), 64'd0);
        step();
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1);
        step();
        check("sub_eq_sum", 64'(sum), 64'd0);
        check("sub_eq_cout", 64'(cout), 64'd1);
        step();

        // Backpressure: capacity of two, then in-order release
        d0 = delivered;
        out_ready = 1'b0;
        send(32'd1, 32'd1, 1'b0, 1'b0);
        send(32'd2, 32'd2, 1'b0, 1'b0);
        a = 32'd3; b = 32'd3; in_valid = 1'b1;
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        step();
        step();
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_sum", 64'(sum), 64'd2);
        out_ready = 1'b1;
        #1;
        check("bp_ready_chain", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        drain();
        for (int i = 0; i < 3; i++) step();
        check("bp_delivered", 64'(delivered - d0), 64'd3);

        // Overflow counter: count, clear collision, saturation at CNT_W=2
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("cnt_cleared", 64'(ovf_cnt), 64'd0);
        for (int i = 0; i < 3; i++) send(32'h4000_0000, 32'h4000_0000 + i, 1'b0, 1'b0);
        drain();
        check("cnt_three", 64'(ovf_cnt), 64'd3);
        check("cnt_three_w2", 64'(ovf_cnt2), 64'd3);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        step();
        check("clr_hit_valid", 64'(out_valid), 64'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("clr_wins", 64'(ovf_cnt), 64'd0);
        check("clr_wins_w2", 64'(ovf_cnt2), 64'd0);
        for (int i = 0; i < 5; i++) send(32'h7000_0000, 32'h7000_0000, 1'b1, 1'b0);
        drain();
        check("cnt_five", 64'(ovf_cnt), 64'd5);
        check("cnt_sat_w2", 64'(ovf_cnt2), 64'd3);

        // Random traffic with a mid-stream reset
        for (int i = 0; i < 300; i++) begin
            a         = $urandom;
            b         = ($urandom_range(0, 3) == 0) ? a : $urandom;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 31) == 0);
            if (i == 150) begin
                out_ready = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
                #1;
                check("midrst_out_valid", 64'(out_valid), 64'd0);
                check("midrst_in_ready", 64'(in_ready), 64'd1);
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        drain();
        for (int i = 0; i < 4; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_bypass_adder.md
# pipelined_bypass_adder

Pipelined, parametrised successor to the team's combinational carry-bypass adder. Adds W-bit signed operands in W/N carry-bypass blocks distributed across STAGES register stages. Supports add/subtract mode, valid/ready flow control with full backpressure, and a saturating overflow event counter. It sits in the datapath wherever a wide adder would otherwise limit fmax.

## Interface
Parameters:
- W, 32, operand/result width; W % N == 0 required.
- N, 4, bits per bypass block.
- STAGES, 2, pipeline register stages; 1 ≤ STAGES ≤ W/N.
- CNT_W, 16, overflow counter width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  W  signed operand A.
- b  in  W  signed operand B.
- cin  in  1  carry/borrow-in.
- sub  in  1  0: a+b+cin; 1: a+~b+(~cin), i.e. a−b−cin.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- sum  out  W  result.
- cout  out  1  raw carry out of MSB.
- overflow  out  1  signed overflow of the raw result.
- ovf_cnt  out  CNT_W  count of delivered overflowing results.
- ovf_clr  in  1  clear ovf_cnt.

## Operation
- Effective operand: b_eff = sub ? ~b : b; c_eff = cin ^ sub.
- Blocks: NB = W/N. Stage k computes blocks [k·BPS, min((k+1)·BPS, NB)), where BPS = ceil(NB/STAGES). The inter-stage carry, the partial sum and the untouched upper operand bits are registered.
- Each block ripples internally. When all N propagate bits (a_i ^ b_eff_i) are 1, the block carry-out is its carry-in (bypass mux); otherwise it is the ripple carry.
- overflow = (a[W-1] == b_eff[W-1]) && (raw_sum[W-1] != a[W-1]).
- Each stage holds a valid bit. A stage loads when it is empty or when its contents advance this cycle. in_ready = stage 0 loads.
- The last stage advances when out_valid && out_ready.
- The block is strictly in-order; no beat is dropped or duplicated.
- ovf_cnt increments by 1 on each handshake (out_valid && out_ready) with overflow=1. It saturates at 2^CNT_W−1 and does not wrap.
- If ovf_clr and an increment occur in the same cycle, ovf_cnt = 0 (clear wins; that event is not counted).

## Timing
- Latency: a beat accepted at edge t is presented at out_valid after edge t+STAGES−1, assuming no stalls.
- Throughput: 1 beat/cycle while out_ready = 1.
- Capacity: STAGES beats. With out_ready = 0, in_ready falls after STAGES accepts.
- in_ready depends combinationally on out_ready (ready chain). No other combinational input-to-output path exists.
- While out_valid = 1 and out_ready = 0, sum/cout/overflow hold stable.
- Reset values: out_valid = 0, sum = 0, cout = 0, overflow = 0, ovf_cnt = 0. in_ready = 1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded and all stage valids cleared. No output appears for them.

## Configuration
- PBA_SATURATE_EN defined: when overflow = 1, sum is clamped to 2^(W−1)−1 if a[W-1] = 0, else to −2^(W−1). cout and overflow still report raw values.
- PBA_SATURATE_EN undefined: sum wraps modulo 2^W. There is no clamp logic.

## Structure
- Shared package adder_pkg holds:
  - the ceil-div function for BPS;
  - the SAT_MAX/SAT_MIN constant functions of W;
  - the stage-payload struct (valid, partial sum, carry, a_hi, b_eff_hi, a_msb, b_msb).
- Sub-module bypass_block (parameter N): inputs a, b, ci; outputs s, co. It is instantiated NB times.

## Test plan
- Reset: assert rst for 2 cycles with in_valid = 1 → out_valid = 0, ovf_cnt = 0, sum = 0; in_ready = 1 after release.
- Add (defaults): a = 21, b = 10, cin = 0, sub = 0 → after 2 edges sum = 31, cout = 0, overflow = 0.
- Overflow: a = 0x40000000, b = 0x40000000 → overflow = 1, ovf_cnt = 1.
  - Without the macro: sum = 0x80000000.
  - With PBA_SATURATE_EN: sum = 0x7FFFFFFF.
- Subtract: a = 5, b = 7, sub = 1, cin = 0 → sum = 0xFFFFFFFE, cout = 0, overflow = 0. Then a = 0x7FFFFFFF, b = 0x7FFFFFFF, sub = 1 → sum = 0, cout = 1.
- Backpressure:
  - Hold out_ready = 0 and push 3 beats (1+1, 2+2, 3+3). in_ready = 0 after 2 accepts and the 3rd waits.
  - Raise out_ready → results 2, 4, 6 delivered in order, each exactly once.
- Counter: deliver 3 overflowing beats → ovf_cnt = 3. Assert ovf_clr in the same cycle as a 4th overflowing delivery → ovf_cnt = 0. With CNT_W = 2, 5 overflows → ovf_cnt = 3.
